matrix_mem_resp: RTL and testbench
==================================

MATRIX_MEM_RESP -- requirements
Module: matrix_mem_resp

Interface
REQ-001 SHALL provide parameter DATA_W, default 256, the matrix row word width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 10, the word address width (1024 words).
REQ-003 SHALL provide parameter WAIT_CYC, default 0, range 0..7, the extra read-return delay in cycles.
REQ-004 SHALL provide port i_clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-005 SHALL provide port i_reset, input, 1 bit, reset, synchronous and active-high.
REQ-006 SHALL provide port i_mem_rreq, input, 1 bit, the read request from the matrix solver.
REQ-007 SHALL provide port i_mem_addr, input, ADDR_W bits, the read word address.
REQ-008 SHALL provide port o_mem_rrdy, output, 1 bit, the responder ready; a request is accepted when i_mem_rreq=1 and o_mem_rrdy=1 at a rising edge.
REQ-009 SHALL provide port o_mem_dout, output, DATA_W bits, the returned read data.
REQ-010 SHALL provide port o_mem_dout_vld, output, 1 bit, the one-cycle read data valid.
REQ-011 SHALL provide port i_ld_wen, input, 1 bit, the host preload write enable.
REQ-012 SHALL provide port i_ld_addr, input, ADDR_W bits, the preload write address.
REQ-013 SHALL provide port i_ld_data, input, DATA_W bits, the preload write data.
REQ-014 SHALL provide port i_stall_en, input, 1 bit, enabling the pseudo-random ready throttling.
REQ-015 SHALL provide port o_sram_cen, output, 1 bit, the SRAM macro chip enable (active-high).
REQ-016 SHALL provide port o_sram_wen, output, 1 bit, the SRAM write enable (1=write).
REQ-017 SHALL provide port o_sram_addr, output, ADDR_W bits, the SRAM address.
REQ-018 SHALL provide port o_sram_din, output, DATA_W bits, the SRAM write data.
REQ-019 SHALL provide port i_sram_dout, input, DATA_W bits, the SRAM read data, valid one cycle after the read edge.
REQ-020 SHALL provide port o_busy, output, 1 bit, high while any accepted read has not yet returned.

Function
REQ-021 SHALL compute o_mem_rrdy combinationally as ~i_ld_wen & ~(i_stall_en & lfsr[0]).
REQ-022 SHALL run an 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, seeded 8'hA5, advancing every cycle regardless of i_stall_en.
REQ-023 SHALL give preload priority: when i_ld_wen=1, drive o_sram_cen=1, o_sram_wen=1, o_sram_addr=i_ld_addr, o_sram_din=i_ld_data, and accept no read that cycle.
REQ-024 SHALL, on read acceptance, drive o_sram_cen=1, o_sram_wen=0, o_sram_addr=i_mem_addr in that same cycle.
REQ-025 SHALL drive o_sram_cen=0 when neither a write nor an accepted read occurs; o_sram_addr and o_sram_din are don't-care then.
REQ-026 SHALL capture i_sram_dout one cycle after the read edge and delay it by WAIT_CYC further register stages.
REQ-027 SHALL assert o_mem_dout_vld for exactly one cycle, starting 2+WAIT_CYC rising edges after the accepting edge, with o_mem_dout holding the addressed word for that cycle.
REQ-028 SHALL drive o_mem_dout to all-zero whenever o_mem_dout_vld=0.
REQ-029 SHALL be fully pipelined: one acceptance per cycle sustained, returns in acceptance order, no gaps in o_mem_dout_vld for back-to-back accepts.
REQ-030 SHALL track in-flight reads with a valid shift register of length 2+WAIT_CYC; o_busy is the OR of all stages.
REQ-031 SHALL return old data for a read accepted at an edge adjacent to a preload of the same address when the write occurs after the read edge.
REQ-032 SHALL ignore i_mem_addr whenever no request is accepted; a dropped request (rrdy=0) produces no return.

Reset
REQ-033 SHALL, while i_reset=1 at a rising edge, clear all valid stages, the data stages and the LFSR (to 8'hA5).
REQ-034 SHALL produce the following outputs after reset: o_mem_dout_vld=0, o_mem_dout=0, o_busy=0; o_sram_cen=0 while i_reset=1; o_mem_rrdy=0 while i_reset=1.
REQ-035 SHALL discard reads in flight at a mid-operation reset with no data returned.

Verification
REQ-036 SHALL cover the scenario: preload addr 0x005=0xA5..A5, WAIT_CYC=0, read 0x005 accepted at edge T -> o_mem_dout_vld=1 only in the cycle after edge T+2, data 0xA5..A5.
REQ-037 SHALL cover the scenario: 16 back-to-back reads of 0x000..0x00F -> 16 consecutive vld cycles in address order, o_busy low two cycles after the last return.
REQ-038 SHALL cover the scenario: i_ld_wen=1 together with i_mem_rreq=1 -> o_mem_rrdy=0, write performed, no return for that cycle.
REQ-039 SHALL cover the scenario: i_stall_en=1, 200 cycles of continuous requests -> accepted count equals returned count, rrdy follows the LFSR bit 0 sequence from 8'hA5.
REQ-040 SHALL cover the scenario: WAIT_CYC=3, single read -> vld 5 edges after acceptance.
REQ-041 SHALL cover the scenario: reset asserted with 2 reads in flight -> no vld afterwards, o_busy=0, o_mem_dout=0.

Source files
------------

// File: rtl/matrix_mem_resp.sv
// Read responder for the matrix solver: fronts a single-port SRAM with host preload
// priority, optional pseudo-random ready throttling and a fixed-latency return pipeline.
module matrix_mem_resp #(
    parameter int DATA_W   = 256,
    parameter int ADDR_W   = 10,
    parameter int WAIT_CYC = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_mem_rreq,
    input  logic [ADDR_W-1:0] i_mem_addr,
    output logic              o_mem_rrdy,
    output logic [DATA_W-1:0] o_mem_dout,
    output logic              o_mem_dout_vld,
    input  logic              i_ld_wen,
    input  logic [ADDR_W-1:0] i_ld_addr,
    input  logic [DATA_W-1:0] i_ld_data,
    input  logic              i_stall_en,
    output logic              o_sram_cen,
    output logic              o_sram_wen,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_din,
    input  logic [DATA_W-1:0] i_sram_dout,
    output logic              o_busy
);

    localparam int VLEN = 2 + WAIT_CYC;

    logic [7:0]        lfsr_q, lfsr_d;
    logic [VLEN-1:0]   vld_sr_q, vld_sr_d;
    logic [DATA_W-1:0] data_sr_q [WAIT_CYC+1];
    logic [DATA_W-1:0] data_sr_d [WAIT_CYC+1];
    logic              dout_vld_q, dout_vld_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              wr_s;
    logic              rd_acc_s;

    // Request handshake and SRAM port steering; preload wins over reads
    always_comb begin
        o_mem_rrdy = ~i_reset & ~i_ld_wen & ~(i_stall_en & lfsr_q[0]);
        wr_s       = ~i_reset & i_ld_wen;
        rd_acc_s   = i_mem_rreq & o_mem_rrdy;
        o_sram_cen = wr_s | rd_acc_s;
        o_sram_wen = wr_s;
        if (wr_s) begin
            o_sram_addr = i_ld_addr;
            o_sram_din  = i_ld_data;
        end else if (rd_acc_s) begin
            o_sram_addr = i_mem_addr;
            o_sram_din  = '0;
        end else begin
            o_sram_addr = '0;
            o_sram_din  = '0;
        end
    end

    // Next-state for LFSR, in-flight valid tags and return data pipeline
    always_comb begin
        lfsr_d       = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        vld_sr_d     = {vld_sr_q[VLEN-2:0], rd_acc_s};
        data_sr_d[0] = i_sram_dout;
        for (int k = 1; k <= WAIT_CYC; k++) begin
            data_sr_d[k] = data_sr_q[k-1];
        end
        dout_vld_d = vld_sr_q[VLEN-1];
        // Data is forced to zero outside the valid cycle so stale words never leak out
        if (vld_sr_q[VLEN-1]) begin
            dout_d = data_sr_q[WAIT_CYC];
        end else begin
            dout_d = '0;
        end
    end

    // State registers; reset drops every in-flight read
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            lfsr_q     <= 8'hA5;
            vld_sr_q   <= '0;
            dout_vld_q <= 1'b0;
            dout_q     <= '0;
            for (int k = 0; k <= WAIT_CYC; k++) begin
                data_sr_q[k] <= '0;
            end
        end else begin
            lfsr_q     <= lfsr_d;
            vld_sr_q   <= vld_sr_d;
            dout_vld_q <= dout_vld_d;
            dout_q     <= dout_d;
            for (int k = 0; k <= WAIT_CYC; k++) begin
                data_sr_q[k] <= data_sr_d[k];
            end
        end
    end

    assign o_mem_dout_vld = dout_vld_q;
    assign o_mem_dout     = dout_q;
    assign o_busy         = |vld_sr_q;

endmodule

// File: tb/tb_matrix_mem_resp.sv
// Scoreboard bench: two responders (WAIT_CYC 0 and 3) share stimulus; each has its own
// SRAM model, expected-return queue and monitor.
module tb_matrix_mem_resp;
    localparam int DW = 256;
    localparam int AW = 10;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
        int            acc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, rreq, wen, stall;
    logic [AW-1:0] addr, laddr;
    logic [DW-1:0] ldata;

    logic [1:0]    rrdy_w, vld_w, busy_w, cen_w, swen_w;
    logic [DW-1:0] dout_w [2];
    logic [DW-1:0] sdin_w [2];
    logic [DW-1:0] srd_q  [2];
    logic [AW-1:0] saddr_w [2];
    logic [DW-1:0] smem [2][1024];

    logic [DW-1:0] ref_mem [1024];
    logic [7:0]    lfsr_m = 8'hA5;
    exp_t          sbq [2][$];
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    int            acc_cnt = 0;
    int            ret_cnt [2] = '{0, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    matrix_mem_resp #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYC(0)) u_dut0 (
        .i_clk(clk), .i_reset(rst), .i_mem_rreq(rreq), .i_mem_addr(addr),
        .o_mem_rrdy(rrdy_w[0]), .o_mem_dout(dout_w[0]), .o_mem_dout_vld(vld_w[0]),
        .i_ld_wen(wen), .i_ld_addr(laddr), .i_ld_data(ldata), .i_stall_en(stall),
        .o_sram_cen(cen_w[0]), .o_sram_wen(swen_w[0]), .o_sram_addr(saddr_w[0]),
        .o_sram_din(sdin_w[0]), .i_sram_dout(srd_q[0]), .o_busy(busy_w[0]));

    matrix_mem_resp #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYC(3)) u_dut3 (
        .i_clk(clk), .i_reset(rst), .i_mem_rreq(rreq), .i_mem_addr(addr),
        .o_mem_rrdy(rrdy_w[1]), .o_mem_dout(dout_w[1]), .o_mem_dout_vld(vld_w[1]),
        .i_ld_wen(wen), .i_ld_addr(laddr), .i_ld_data(ldata), .i_stall_en(stall),
        .o_sram_cen(cen_w[1]), .o_sram_wen(swen_w[1]), .o_sram_addr(saddr_w[1]),
        .o_sram_din(sdin_w[1]), .i_sram_dout(srd_q[1]), .o_busy(busy_w[1]));

    // Single-port SRAM behaviour: read data appears the cycle after the read edge
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (cen_w[i] === 1'b1) begin
                if (swen_w[i] === 1'b1) smem[i][saddr_w[i]] <= sdin_w[i];
                else                    srd_q[i] <= smem[i][saddr_w[i]];
            end
        end
    end

    function automatic int wt(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], ^(l & 8'hB8)};
    endfunction

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] w;
        for (int k = 0; k < DW / 32; k++) w[32*k +: 32] = $urandom;
        return w;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d act=%h exp=%h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: return timing, data and busy against the scoreboard queues
    always @(negedge clk) begin
        logic          ev;
        logic [DW-1:0] ed;
        int            inflt;
        for (int i = 0; i < 2; i++) begin
            ev = (sbq[i].size() > 0) && (sbq[i][0].due == cyc);
            ed = ev ? sbq[i][0].data : '0;
            chk($sformatf("vld%0d", wt(i)), DW'(vld_w[i]), DW'(ev));
            chk($sformatf("dout%0d", wt(i)), dout_w[i], ed);
            if (ev) begin
                void'(sbq[i].pop_front());
                ret_cnt[i]++;
            end
            inflt = 0;
            foreach (sbq[i][k]) if (sbq[i][k].acc <= cyc) inflt++;
            chk($sformatf("busy%0d", wt(i)), DW'(busy_w[i]), DW'(inflt > 0));
        end
    end

    // One clock of stimulus: drive, check handshake/SRAM port at negedge, advance model
    task automatic step(input bit r, input bit rq, input int a, input bit w,
                        input int la, input logic [DW-1:0] ld, input bit st);
        bit   erdy, acc, ewr, ecen;
        exp_t e;
        rst = r; rreq = rq; addr = AW'(a); wen = w; laddr = AW'(la); ldata = ld; stall = st;
        @(negedge clk);
        erdy = !r && !w && !(st && lfsr_m[0]);
        acc  = rq && erdy;
        ewr  = w && !r;
        ecen = ewr || acc;
        for (int i = 0; i < 2; i++) begin
            chk("rrdy", DW'(rrdy_w[i]), DW'(erdy));
            chk("sram_cen", DW'(cen_w[i]), DW'(ecen));
            if (ecen) begin
                chk("sram_wen", DW'(swen_w[i]), DW'(ewr));
                chk("sram_addr", DW'(saddr_w[i]), ewr ? DW'(la) : DW'(a));
            end
            if (ewr) chk("sram_din", sdin_w[i], ld);
            if (acc) begin
                e.data = ref_mem[a];
                e.due  = cyc + 3 + wt(i);
                e.acc  = cyc + 1;
                sbq[i].push_back(e);
            end
        end
        if (acc) acc_cnt++;
        if (ewr) ref_mem[la] = ld;
        @(posedge clk);
        lfsr_m = r ? 8'hA5 : lfsr_next(lfsr_m);
        if (r) begin
            sbq[0].delete();
            sbq[1].delete();
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 0, 1'b0, 0, '0, 1'b0);
    endtask

    initial begin
        int      base_acc;
        int      base_ret [2];
        bit      rq, w, st;
        logic [DW-1:0] pat;
        rst = 1'b1; rreq = 1'b0; wen = 1'b0; stall = 1'b0;
        addr = '0; laddr = '0; ldata = '0;
        #1;
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 0, 1'b0, 0, '0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", DW'(busy_w[i]), '0);
            chk("rst_dout", dout_w[i], '0);
        end

        // Preload words 0..63; word 5 gets the A5 pattern
        pat = {32{8'hA5}};
        for (int a = 0; a < 64; a++) step(1'b0, 1'b0, 0, 1'b1, a, (a == 5) ? pat : rnd_word(), 1'b0);

        // Single read, then 16 back-to-back reads
        step(1'b0, 1'b1, 5, 1'b0, 0, '0, 1'b0);
        idle(8);
        base_acc = acc_cnt; base_ret = ret_cnt;
        for (int a = 0; a < 16; a++) step(1'b0, 1'b1, a, 1'b0, 0, '0, 1'b0);
        idle(10);
        for (int i = 0; i < 2; i++) chk("b2b_count", DW'(ret_cnt[i] - base_ret[i]), DW'(16));

        // Preload colliding with a request, then a read right before a write of the same word
        step(1'b0, 1'b1, 7, 1'b1, 7, rnd_word(), 1'b0);
        step(1'b0, 1'b1, 7, 1'b0, 0, '0, 1'b0);
        step(1'b0, 1'b1, 9, 1'b0, 0, '0, 1'b0);
        step(1'b0, 1'b0, 0, 1'b1, 9, rnd_word(), 1'b0);
        step(1'b0, 1'b1, 9, 1'b0, 0, '0, 1'b0);
        idle(8);

        // Throttled continuous requests
        base_acc = acc_cnt; base_ret = ret_cnt;
        for (int k = 0; k < 200; k++) step(1'b0, 1'b1, $urandom_range(0, 63), 1'b0, 0, '0, 1'b1);
        idle(10);
        for (int i = 0; i < 2; i++)
            chk("stall_acc_ret", DW'(ret_cnt[i] - base_ret[i]), DW'(acc_cnt - base_acc));

        // Random mix of reads, preloads and throttling
        for (int k = 0; k < 300; k++) begin
            rq = ($urandom_range(0, 3) != 0);
            w  = ($urandom_range(0, 7) == 0);
            st = ($urandom_range(0, 1) == 1);
            step(1'b0, rq, $urandom_range(0, 63), w, $urandom_range(0, 63), rnd_word(), st);
        end
        idle(10);

        // Reset with two reads in flight
        step(1'b0, 1'b1, 1, 1'b0, 0, '0, 1'b0);
        step(1'b0, 1'b1, 2, 1'b0, 0, '0, 1'b0);
        step(1'b1, 1'b1, 3, 1'b0, 0, '0, 1'b0);
        idle(10);
        for (int i = 0; i < 2; i++) begin
            chk("midrst_busy", DW'(busy_w[i]), '0);
            chk("midrst_dout", dout_w[i], '0);
            chk("drain", DW'(sbq[i].size()), '0);
        end
        step(1'b0, 1'b1, 5, 1'b0, 0, '0, 1'b0);
        idle(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
